// File: rtl/sprite_pixel_packer.sv
// Streams 24-bit pixels into an SRAM as RGB565 words, one handshake per write burst.
// Optional macro RGB565_ROUND_EN selects round-to-nearest with saturation instead of truncation.
module sprite_pixel_packer #(
  parameter int ADDR_W      = 20,
  parameter int PIXEL_COUNT = 76800,
  parameter int WR_CYCLES   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_R,
  input  logic [7:0]        in_G,
  input  logic [7:0]        in_B,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  output logic              sram_we,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [15:0]       packed_px;
  logic              last_wr, last_px;

`ifdef RGB565_ROUND_EN
  logic [8:0] r_sum, g_sum, b_sum;

  // Bit 8 of each sum flags the one rounding result that overflows the field.
  assign r_sum = {1'b0, in_R} + 9'd4;
  assign g_sum = {1'b0, in_G} + 9'd2;
  assign b_sum = {1'b0, in_B} + 9'd4;
  assign packed_px = {r_sum[8] ? 5'd31 : r_sum[7:3],
                      g_sum[8] ? 6'd63 : g_sum[7:2],
                      b_sum[8] ? 5'd31 : b_sum[7:3]};
`else
  logic unused_low_bits;

  assign packed_px       = {in_R[7:3], in_G[7:2], in_B[7:3]};
  assign unused_low_bits = ^{in_R[2:0], in_G[1:0], in_B[2:0]};
`endif

  assign last_wr = (wcnt_q == 4'(WR_CYCLES - 1));
  assign last_px = (count_q == CNT_W'(PIXEL_COUNT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // NOTE: every signal driven here gets a hold default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = '0;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          addr_d  = base_q + ADDR_W'(count_q);
          wdata_d = packed_px;
          wcnt_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_wr) begin
          if (last_px) begin
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
            state_d = ACCEPT;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == ACCEPT);
    sram_we    = (state_q == WRITE);
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_sprite_pixel_packer.sv
// Randomized self-checking bench for sprite_pixel_packer against a pixel-level reference model.
module tb_sprite_pixel_packer;

  localparam int AW = 20;
  localparam int PC = 4;
  localparam int WR = 2;

  logic          Clk = 1'b0;
  logic          Reset, start, in_valid, in_ready, sram_we, busy, done;
  logic [AW-1:0] base_addr, sram_addr;
  logic [7:0]    in_R, in_G, in_B;
  logic [15:0]   sram_wdata;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  sprite_pixel_packer #(.ADDR_W(AW), .PIXEL_COUNT(PC), .WR_CYCLES(WR)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_R(in_R), .in_G(in_G), .in_B(in_B),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_pack(input int r, input int g, input int b);
    int r5, g6, b5;
`ifdef RGB565_ROUND_EN
    r5 = (r + 4) / 8;  if (r5 > 31) r5 = 31;
    g6 = (g + 2) / 4;  if (g6 > 63) g6 = 63;
    b5 = (b + 4) / 8;  if (b5 > 31) b5 = 31;
`else
    r5 = r / 8;
    g6 = g / 4;
    b5 = b / 8;
`endif
    return 16'(r5 * 2048 + g6 * 32 + b5);
  endfunction

  function automatic logic [AW-1:0] ref_addr(input int base, input int idx);
    return AW'((base + idx) % (1 << AW));
  endfunction

  // stall_mode: 0 = in_valid held high, 1 = 5-cycle gaps, 2 = random gaps
  task automatic run_load(input logic [AW-1:0] base, input int stall_mode,
                          input bit fixed_first, input int abort_px);
    int r[PC], g[PC], b[PC], t_first[PC];
    int stall;
    logic [15:0] ew;
    logic [AW-1:0] ea;
    for (int i = 0; i < PC; i++) begin
      r[i] = $urandom_range(0, 255);
      g[i] = $urandom_range(0, 255);
      b[i] = $urandom_range(0, 255);
    end
    if (fixed_first) begin
      r[0] = 'hFF; g[0] = 'h80; b[0] = 'h07;
    end
    @(negedge Clk);
    start = 1'b1; base_addr = base;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0; base_addr = AW'($urandom);
    for (int i = 0; i < PC; i++) begin
      stall = (stall_mode == 1) ? 5 : (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (stall > 0) in_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        vectors++;
        if ({in_ready, sram_we, busy} !== 3'b101) begin
          miscompares++;
          $display("FAIL stall px%0d: rdy/we/busy=%b expected 101", i, {in_ready, sram_we, busy});
        end
        @(negedge Clk);
      end
      in_valid = 1'b1;
      in_R = 8'(r[i]); in_G = 8'(g[i]); in_B = 8'(b[i]);
      vectors++;
      if ({in_ready, sram_we} !== 2'b10) begin
        miscompares++;
        $display("FAIL accept px%0d: rdy/we=%b expected 10", i, {in_ready, sram_we});
      end
      @(posedge Clk);
      @(negedge Clk);
      t_first[i] = cyc;
      ew = ref_pack(r[i], g[i], b[i]);
      ea = ref_addr(int'(base), i);
      if (i == abort_px) begin
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0; in_valid = 1'b0;
        vectors++;
        if ({sram_we, in_ready, busy, done, sram_addr, sram_wdata} !== '0) begin
          miscompares++;
          $display("FAIL abort: we/rdy/busy/done=%b addr=%h data=%h expected all zero",
                   {sram_we, in_ready, busy, done}, sram_addr, sram_wdata);
        end
        return;
      end
      if (stall_mode == 0 && i < PC - 1) begin
        in_R = 8'(r[i + 1]); in_G = 8'(g[i + 1]); in_B = 8'(b[i + 1]);
      end else begin
        in_valid = 1'b0;
        in_R = 8'($urandom); in_G = 8'($urandom); in_B = 8'($urandom);
      end
`ifndef RGB565_ROUND_EN
      vectors++;
      if ({sram_wdata[15:11], 3'b000, sram_wdata[10:5], 2'b00, sram_wdata[4:0], 3'b000} !==
          {8'(r[i]) & 8'hF8, 8'(g[i]) & 8'hFC, 8'(b[i]) & 8'hF8}) begin
        miscompares++;
        $display("FAIL roundtrip px%0d: word=%h expected from pixel %h%h%h", i, sram_wdata,
                 8'(r[i]), 8'(g[i]), 8'(b[i]));
      end
`endif
      for (int j = 0; j < WR; j++) begin
        vectors++;
        if ({sram_we, in_ready, busy, done, sram_addr, sram_wdata} !== {4'b1010, ea, ew}) begin
          miscompares++;
          $display("FAIL write px%0d c%0d: we/rdy/busy/done=%b addr=%h data=%h expected 1010 %h %h",
                   i, j, {sram_we, in_ready, busy, done}, sram_addr, sram_wdata, ea, ew);
        end
        @(negedge Clk);
      end
      if (i < PC - 1) begin
        vectors++;
        if ({sram_we, in_ready, busy, done, sram_addr, sram_wdata} !== {4'b0110, ea, ew}) begin
          miscompares++;
          $display("FAIL post px%0d: we/rdy/busy/done=%b addr=%h data=%h expected 0110 %h %h",
                   i, {sram_we, in_ready, busy, done}, sram_addr, sram_wdata, ea, ew);
        end
      end else begin
        vectors++;
        if ({sram_we, in_ready, busy, done} !== 4'b0011) begin
          miscompares++;
          $display("FAIL done: we/rdy/busy/done=%b expected 0011", {sram_we, in_ready, busy, done});
        end
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
          vectors++;
          if ({sram_we, in_ready, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle%0d: we/rdy/busy/done=%b expected 0000", k,
                     {sram_we, in_ready, busy, done});
          end
          @(negedge Clk);
        end
      end
      if (i > 0 && stall_mode == 0) begin
        vectors++;
        if (t_first[i] - t_first[i - 1] !== WR + 1) begin
          miscompares++;
          $display("FAIL spacing px%0d: %0d cycles expected %0d", i,
                   t_first[i] - t_first[i - 1], WR + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; in_valid = 1'b1; base_addr = '0;
    in_R = 8'hAA; in_G = 8'h55; in_B = 8'hFF;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    vectors++;
    if ({sram_we, in_ready, busy, done, sram_addr, sram_wdata} !== '0) begin
      miscompares++;
      $display("FAIL reset: we/rdy/busy/done=%b addr=%h data=%h expected all zero",
               {sram_we, in_ready, busy, done}, sram_addr, sram_wdata);
    end
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({sram_we, in_ready, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_no_start: we/rdy/busy/done=%b expected 0000",
               {sram_we, in_ready, busy, done});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_truncation();
    run_load(20'h00100, 2, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    run_load(AW'($urandom), 0, 1'b0, -1);
  endtask

  task automatic test_wrap_stall();
    run_load(20'hFFFFF, 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_write();
    run_load(AW'($urandom), 0, 1'b0, 1);
    run_load(AW'($urandom), 0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) run_load(AW'($urandom), 2, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_truncation();
    test_back_to_back();
    test_wrap_stall();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
